ota_duty_meter: RTL and testbench
=================================

// Module: ota_duty_meter
// PURPOSE
//  Multi-channel successor to the single digital-OTA comparator hookup.
//  Samples N_CH asynchronous comparator outputs (one per digital OTA instance) and synchronises them.
//  Glitch-filters each level and measures each channel's high-time over a fixed window, so each channel acts as a 1-bit ADC.
//  Sits between the OTA array and the uo_out/uio pins; results are read one channel at a time through a select mux with a valid/ack handshake.
// PARAMETERS
//  N_CH         2  number of comparator channels (1..8)
//  CNT_W        8  window = 2**CNT_W enabled cycles; result width
//  SYNC_STAGES  2  synchroniser flops per channel (>=2)
//  STABLE       3  consecutive equal samples before cmp_filt changes (>=1)
//  SEL_W        derived, max(1,$clog2(N_CH)); not overridable
// PORTS
//  clk           in   1       single clock; all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  en            in   1       1 = measure; 0 = hold in IDLE
//  cmp_in        in   N_CH    async comparator outputs, one bit per channel
//  ch_sel        in   SEL_W   selects channel driven onto result
//  result_ack    in   1       1-cycle pulse; consumes the pending result set
//  cmp_filt      out  N_CH    glitch-filtered comparator levels
//  result        out  CNT_W   latched high-count of channel ch_sel
//  result_valid  out  1       result set pending
//  overrun       out  1       sticky; window ended while a result was unacknowledged
// BEHAVIOUR
//  Reset: all synchroniser, filter, counter and result regs = 0.
//   cmp_filt=0, result=0, result_valid=0, overrun=0, FSM=IDLE.
//  Synchroniser: sync[c] = cmp_in[c] delayed SYNC_STAGES clocks. The sync chain runs regardless of en.
//  Filter, per channel: run counter of consecutive sync[c] != cmp_filt[c].
//   - Counter resets on a match.
//   - When it reaches STABLE, cmp_filt[c] toggles and the counter clears.
//   - Pulses shorter than STABLE cycles never appear on cmp_filt.
//   - The filter runs regardless of en.
//  FSM:
//   - IDLE: win_cnt=0, hi_cnt[*]=0. Goes to RUN when en=1.
//   - RUN: each cycle win_cnt++ and hi_cnt[c] += sync[c] (raw, not filtered). Goes to IDLE when en=0; partial window discarded, no result.
//   - Re-entering RUN starts a fresh window.
//  Window end: the RUN cycle with win_cnt == 2**CNT_W-1.
//   - Computes res[c] = hi_cnt[c] + sync[c], saturated to 2**CNT_W-1 (all-high window reports all-ones).
//   - res[*] is latched into the result bank and hi_cnt/win_cnt clear.
//   - Next window starts on the next cycle with no gap.
//   - result_valid goes to 1 on the following cycle.
//  Handshake:
//   - result_valid stays high until a cycle with result_ack=1, then drops to 0 on the next cycle.
//   - result_ack with result_valid=0 is ignored.
//  Simultaneous window end and result_ack:
//   - The ack consumes the old set; the new set is latched.
//   - result_valid stays 1; overrun is not set.
//  Window end with result_valid=1 and no ack:
//   - The bank is overwritten with the newest set.
//   - overrun is set to 1 and stays set until the next result_ack or rst.
//  result = bank[ch_sel], combinational mux. ch_sel >= N_CH gives result = 0.
//  rst mid-window: everything clears and FSM=IDLE. With en=1 and rst released, the first result_valid appears 2**CNT_W+1 cycles after the release edge.
// TESTING (N_CH=2, CNT_W=4, SYNC_STAGES=2, STABLE=3)
//  1. Assert rst 2 cycles.
//     -> cmp_filt=00, result=0, result_valid=0, overrun=0.
//  2. en=1, cmp_in=2'b01 held; ack each valid.
//     -> 2nd window ch_sel=0: result=15; ch_sel=1: result=0; cmp_filt=01.
//  3. cmp_in[0] toggles every cycle (50%).
//     -> steady-state windows give result=8 on ch0.
//  4. No ack across 2 windows.
//     -> overrun=1, result = 2nd-window value.
//     -> ack: valid=0, overrun=0 next cycle.
//  5. cmp_in[1] pulse of 2 cycles -> cmp_filt[1] stays 0.
//     Pulse of 4 cycles -> cmp_filt[1] rises 5 cycles after the input edge.
//  6. rst at window cycle 9, then en=1.
//     -> no result from the aborted window; valid 17 cycles after rst release.
//     en low at cycle 5 -> no valid and no overrun change.

Source files
------------

// File: rtl/ota_duty_meter.sv
`default_nettype none
// ============================================================================
// Module  : ota_duty_meter
// Brief   : Per-channel comparator synchroniser, glitch filter and windowed
//           high-time meter with a valid/ack result bank.
// Revision: 1.0 - initial release
// ============================================================================
module ota_duty_meter #(
    parameter  int N_CH        = 2,
    parameter  int CNT_W       = 8,
    parameter  int SYNC_STAGES = 2,
    parameter  int STABLE      = 3,
    localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  cmp_in,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic             result_ack,
    output logic [N_CH-1:0]  cmp_filt,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overrun
);

    localparam int              c_run_w    = $clog2(STABLE + 1);
    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(STABLE - 1);
    localparam logic [CNT_W-1:0]   c_win_last = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_CH-1:0]    r_sync [SYNC_STAGES];
    logic [N_CH-1:0]    w_sync;
    logic [c_run_w-1:0] r_run [N_CH];
    logic [N_CH-1:0]    r_filt;
    logic [CNT_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   r_hi_cnt [N_CH];
    logic [CNT_W:0]     w_sum [N_CH];
    logic [CNT_W-1:0]   w_res [N_CH];
    logic [CNT_W-1:0]   r_bank [N_CH];
    logic               r_valid;
    logic               r_overrun;
    logic               w_win_end;
    logic               w_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= cmp_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Filter counter tracks consecutive samples disagreeing with the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= '0;
            for (int c = 0; c < N_CH; c++) r_run[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_sync[c] != r_filt[c]) begin
                    if (r_run[c] == c_run_last) begin
                        r_filt[c] <= ~r_filt[c];
                        r_run[c]  <= '0;
                    end else begin
                        r_run[c] <= r_run[c] + 1'b1;
                    end
                end else begin
                    r_run[c] <= '0;
                end
            end
        end
    end

    assign cmp_filt = r_filt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en)  w_state_nxt = S_RUN;
            S_RUN:   if (!en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_win_end = (r_state == S_RUN) && en && (r_win_cnt == c_win_last);
    assign w_ack     = result_ack && r_valid;

    // The final cycle's sample is folded in here, so a full window can reach 2**CNT_W.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_sum[c] = {1'b0, r_hi_cnt[c]} + (CNT_W+1)'(w_sync[c]);
            w_res[c] = w_sum[c][CNT_W] ? c_win_last : w_sum[c][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_RUN) || !en || w_win_end) begin
            r_win_cnt <= '0;
            for (int c = 0; c < N_CH; c++) r_hi_cnt[c] <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            for (int c = 0; c < N_CH; c++) r_hi_cnt[c] <= r_hi_cnt[c] + CNT_W'(w_sync[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) r_bank[c] <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_win_end) begin
                for (int c = 0; c < N_CH; c++) r_bank[c] <= w_res[c];
            end
            if (w_win_end)  r_valid <= 1'b1;
            else if (w_ack) r_valid <= 1'b0;
            if (w_ack)                     r_overrun <= 1'b0;
            else if (w_win_end && r_valid) r_overrun <= 1'b1;
        end
    end

    always_comb begin
        result = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel == SEL_W'(c)) result = r_bank[c];
        end
    end

    assign result_valid = r_valid;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ota_duty_meter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ota_duty_meter
// Brief   : Self-checking bench for ota_duty_meter (N_CH=2, CNT_W=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ota_duty_meter;

    localparam int N_CH = 2;
    localparam int CNT_W = 4;
    localparam int SYNC_STAGES = 2;
    localparam int STABLE = 3;
    localparam int WIN = 1 << CNT_W;
    localparam int MAXV = WIN - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [N_CH-1:0]  cmp_in = '0;
    logic             ch_sel = 1'b0;
    logic             result_ack = 1'b0;
    logic [N_CH-1:0]  cmp_filt;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             overrun;

    int checks = 0;
    int failures = 0;

    ota_duty_meter #(
        .N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .STABLE(STABLE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in), .ch_sel(ch_sel),
        .result_ack(result_ack), .cmp_filt(cmp_filt), .result(result),
        .result_valid(result_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: history of sampled inputs, windows as lists of samples.
    logic [N_CH-1:0] hist[$];
    logic [N_CH-1:0] shist[$];
    logic [N_CH-1:0] m_filt;
    int              m_last_tog[N_CH];
    int              m_cyc;
    bit              m_run;
    logic [N_CH-1:0] m_bits[$];
    int              m_bank[N_CH];
    bit              m_valid;
    bit              m_ovr;
    int              m_windows;

    always @(posedge clk) begin
        logic [N_CH-1:0] s;
        bit all_diff;
        bit wend;
        int sum;
        if (rst) begin
            hist = {}; shist = {}; m_bits = {};
            m_filt = '0; m_cyc = 0; m_run = 0; m_valid = 0; m_ovr = 0;
            for (int c = 0; c < N_CH; c++) begin m_bank[c] = 0; m_last_tog[c] = -100; end
        end else begin
            s = (hist.size() >= SYNC_STAGES) ? hist[SYNC_STAGES-1] : '0;
            hist.push_front(cmp_in);
            if (hist.size() > SYNC_STAGES) void'(hist.pop_back());
            m_cyc++;
            shist.push_front(s);
            if (shist.size() > STABLE) void'(shist.pop_back());
            for (int c = 0; c < N_CH; c++) begin
                if (shist.size() >= STABLE) begin
                    all_diff = 1;
                    for (int k = 0; k < STABLE; k++)
                        if (shist[k][c] == m_filt[c] || (m_cyc - k) <= m_last_tog[c]) all_diff = 0;
                    if (all_diff) begin m_filt[c] = ~m_filt[c]; m_last_tog[c] = m_cyc; end
                end
            end
            wend = 0;
            if (!m_run) begin
                if (en) begin m_run = 1; m_bits = {}; end
            end else if (!en) begin
                m_run = 0; m_bits = {};
            end else begin
                m_bits.push_back(s);
                if (m_bits.size() == WIN) begin
                    for (int c = 0; c < N_CH; c++) begin
                        sum = 0;
                        foreach (m_bits[k]) sum += int'(m_bits[k][c]);
                        m_bank[c] = (sum > MAXV) ? MAXV : sum;
                    end
                    m_bits = {};
                    wend = 1;
                    m_windows++;
                end
            end
            if (result_ack && m_valid) m_ovr = 0;
            else if (wend && m_valid) m_ovr = 1;
            if (wend) m_valid = 1;
            else if (result_ack) m_valid = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; en = 0; cmp_in = 2'b11; result_ack = 0;
        step(); step();
        checks++; if (cmp_filt !== 2'b00) begin failures++; $display("FAIL reset_cmp_filt got=%b exp=00", cmp_filt); end
        checks++; if (result !== 4'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        cmp_in = 2'b00;
    endtask

    task automatic test_held();
        int got = 0;
        rst = 0; en = 1; cmp_in = 2'b01;
        for (int i = 0; i < 100 && got < 2; i++) begin
            step();
            if (result_valid) begin
                got++;
                if (got == 2) begin
                    ch_sel = 0; #1;
                    checks++; if (result !== 4'd15) begin failures++; $display("FAIL held_ch0 got=%0d exp=15", result); end
                    ch_sel = 1; #1;
                    checks++; if (result !== 4'd0) begin failures++; $display("FAIL held_ch1 got=%0d exp=0", result); end
                    checks++; if (cmp_filt !== 2'b01) begin failures++; $display("FAIL held_filt got=%b exp=01", cmp_filt); end
                end
                result_ack = 1; step(); result_ack = 0;
                checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL held_ack_valid got=%b exp=0", result_valid); end
            end
        end
        checks++; if (got != 2) begin failures++; $display("FAIL held_timeout got=%0d exp=2 windows", got); end
    endtask

    task automatic test_half();
        int got = 0;
        ch_sel = 0;
        for (int i = 0; i < 200 && got < 3; i++) begin
            cmp_in[0] = ~cmp_in[0];
            step();
            if (result_valid) begin
                got++;
                #1;
                if (got >= 2) begin
                    checks++; if (result !== 4'd8) begin failures++; $display("FAIL half_ch0 got=%0d exp=8", result); end
                end
                checks++; if (result !== 4'(m_bank[0])) begin failures++; $display("FAIL half_model got=%0d exp=%0d", result, m_bank[0]); end
                result_ack = 1; cmp_in[0] = ~cmp_in[0]; step(); result_ack = 0;
            end
        end
        checks++; if (got != 3) begin failures++; $display("FAIL half_timeout got=%0d exp=3 windows", got); end
    endtask

    task automatic test_overrun();
        int i;
        cmp_in = 2'b01;
        for (i = 0; i < 60 && !result_valid; i++) step();
        result_ack = 1; step(); result_ack = 0;
        for (i = 0; i < 60 && !result_valid; i++) step();
        checks++; if (!result_valid) begin failures++; $display("FAIL ovr_wait got=valid0 exp=valid1"); end
        cmp_in = 2'b11;
        for (int k = 0; k < WIN; k++) step();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", result_valid); end
        ch_sel = 0; #1;
        checks++; if (result !== 4'd15) begin failures++; $display("FAIL ovr_ch0 got=%0d exp=15", result); end
        ch_sel = 1; #1;
        checks++; if (result !== 4'd14) begin failures++; $display("FAIL ovr_ch1 got=%0d exp=14", result); end
        result_ack = 1; step(); result_ack = 0;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL ovr_ack_valid got=%b exp=0", result_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_glitch();
        en = 0; cmp_in = 2'b00;
        for (int k = 0; k < 10; k++) step();
        checks++; if (cmp_filt !== 2'b00) begin failures++; $display("FAIL glitch_settle got=%b exp=00", cmp_filt); end
        cmp_in[1] = 1; step(); step(); cmp_in[1] = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (cmp_filt[1] !== 1'b0) begin failures++; $display("FAIL glitch_short got=%b exp=0", cmp_filt[1]); end
        end
        cmp_in[1] = 1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (cmp_filt[1] !== (k == 5)) begin
                failures++; $display("FAIL glitch_long cyc=%0d got=%b exp=%b", k, cmp_filt[1], (k == 5));
            end
        end
        cmp_in[1] = 0;
    endtask

    task automatic test_back_to_back();
        int i;
        en = 1; cmp_in = 2'(($urandom));
        for (i = 0; i < 100 && !(m_ovr && m_bits.size() == WIN - 1); i++) begin
            cmp_in = 2'($urandom);
            step();
        end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_pre_ovr got=%b exp=1", overrun); end
        result_ack = 1; step(); result_ack = 0;
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", result_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", overrun); end
        ch_sel = 1; #1;
        checks++; if (result !== 4'(m_bank[1])) begin failures++; $display("FAIL b2b_result got=%0d exp=%0d", result, m_bank[1]); end
        result_ack = 1; step(); result_ack = 0;
    endtask

    task automatic test_rst_mid();
        int first = -1;
        bit ovr0;
        en = 1; cmp_in = 2'b10;
        for (int i = 0; i < 60 && m_bits.size() != 9; i++) step();
        rst = 1; step(); rst = 0;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            step();
            if (result_valid) first = k;
        end
        checks++; if (first != WIN + 1) begin failures++; $display("FAIL rst_mid_latency got=%0d exp=%0d", first, WIN + 1); end
        ch_sel = 1; #1;
        checks++; if (result !== 4'(m_bank[1])) begin failures++; $display("FAIL rst_mid_result got=%0d exp=%0d", result, m_bank[1]); end
        result_ack = 1; step(); result_ack = 0;
        for (int i = 0; i < 60 && m_bits.size() != 5; i++) step();
        ovr0 = overrun;
        en = 0;
        for (int k = 0; k < 20; k++) step();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL en_low_valid got=%b exp=0", result_valid); end
        checks++; if (overrun !== ovr0) begin failures++; $display("FAIL en_low_ovr got=%b exp=%b", overrun, ovr0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            cmp_in = ($urandom_range(0, 3) == 0) ? 2'($urandom) : cmp_in ^ 2'($urandom_range(0, 1));
            en = ($urandom_range(0, 39) != 0);
            result_ack = ($urandom_range(0, 9) < 3);
            step();
            ch_sel = 1'($urandom); #1;
            checks++;
            if (cmp_filt !== m_filt || result_valid !== m_valid || overrun !== m_ovr
                || result !== 4'(m_bank[ch_sel])) begin
                failures++;
                $display("FAIL random cyc=%0d got filt=%b v=%b o=%b r=%0d exp filt=%b v=%b o=%b r=%0d",
                         i, cmp_filt, result_valid, overrun, result, m_filt, m_valid, m_ovr, m_bank[ch_sel]);
            end
        end
        result_ack = 0; en = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_held();
        test_half();
        test_overrun();
        test_glitch();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
